// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM encoding
// and a constant-width helper.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Bits needed to index n items; never below 1 so single-bit ids stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after ptr, wrapping modulo N_REQ.
module rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid one wins last.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(N_REQ)) sum = sum - (ID_W + 1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one clock-gated ALU among N_REQ requesters: round-robin grant, one
// operation in flight, locally computed zero flag and a saturating op counter.
module alu_rr_sched
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int CNT_W = 16,
    localparam int ID_W = clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*3-1:0] req_op,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [2:0]         alu_op,
    output logic               alu_en,
    input  logic [W-1:0]       alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_result,
    output logic               rsp_zero,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count,
    output state_e             state_dbg
);

    // valid/ready: a transfer happens on a rising edge where both are high;
    // the source holds valid and its payload until then, and may withdraw
    // valid only while ready is low.

    state_e           state, state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic             accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant_any) state_next = ISSUE;
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept    = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // alu_en is the registered accept, so it is high for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_en     <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            alu_en <= accept;
            if (accept) begin
                alu_a  <= req_a[grant_id*W +: W];
                alu_b  <= req_b[grant_id*W +: W];
                alu_op <= req_op[grant_id*3 +: 3];
                rsp_id <= grant_id;
                rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state == CAPTURE) begin
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == '0);
            end
            if (rsp_valid && rsp_ready && (op_count != '1)) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
